cb_wb_arbiter: RTL and testbench

CB_WB_ARBITER -- requirements
Module: cb_wb_arbiter

---
 rtl/cb_wb_arbiter.sv | 116 +++++++++++
 tb/tb_cb_wb_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_wb_arbiter.sv
// cb_wb_arbiter: completion-buffer write-port arbiter for NUM_REQ functional units.
// Aged (urgent) requesters win lowest-index first; otherwise round-robin from rr_ptr.
// Ports: CLK, nRST (sync, active-low); req_valid/index/data/vd/exc per requester;
//        req_ready one-hot grant (comb); flush; wb_* registered write port; age_urgent.
module cb_wb_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int NUM_ENTRY = 16,
   parameter int AGE_LIMIT = 8,
   localparam int IW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1,
   localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CW = $clog2(AGE_LIMIT) + 1
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*IW-1:0] req_index,
   input  logic [NUM_REQ*32-1:0] req_data,
   input  logic [NUM_REQ*5-1:0]  req_vd,
   input  logic [NUM_REQ-1:0]    req_exc,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic                  flush,
   output logic                  wb_valid,
   output logic [IW-1:0]         wb_index,
   output logic [31:0]           wb_data,
   output logic [4:0]            wb_vd,
   output logic                  wb_exc,
   output logic [SW-1:0]         wb_src,
   output logic [NUM_REQ-1:0]    age_urgent
);

   logic [SW-1:0]      r_rr_ptr;
   logic [CW-1:0]      r_wait [NUM_REQ];
   logic [NUM_REQ-1:0] r_urgent;

   logic               w_arb_en;
   logic               w_gnt_any;
   logic [SW-1:0]      w_gnt_idx;
   logic [NUM_REQ-1:0] w_gnt;
   logic [CW-1:0]      w_wait_nxt [NUM_REQ];
   logic [NUM_REQ-1:0] w_urg_nxt;
   int                 w_j;

   // Reset and flush both suppress any grant this cycle.
   assign w_arb_en = nRST && !flush;

   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      w_j       = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!w_gnt_any && r_urgent[i] && req_valid[i]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = SW'(i);
         end
      end
      // Round-robin pass only matters when no urgent requester won.
      for (int k = 0; k < NUM_REQ; k++) begin
         w_j = int'(r_rr_ptr) + k;
         if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
         if (!w_gnt_any && req_valid[SW'(w_j)]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = SW'(w_j);
         end
      end
      if (!w_arb_en) w_gnt_any = 1'b0;
   end

   always_comb begin
      w_gnt = '0;
      if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
   end

   assign req_ready  = w_gnt;
   assign age_urgent = r_urgent;

   // Wait counters saturate at AGE_LIMIT; urgent flag tracks the new count.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         w_wait_nxt[i] = '0;
         if (!flush && req_valid[i] && !w_gnt[i]) begin
            if (r_wait[i] == CW'(AGE_LIMIT)) w_wait_nxt[i] = r_wait[i];
            else w_wait_nxt[i] = r_wait[i] + 1'b1;
         end
         w_urg_nxt[i] = (w_wait_nxt[i] == CW'(AGE_LIMIT));
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_rr_ptr <= '0;
         r_urgent <= '0;
         wb_valid <= 1'b0;
         wb_index <= '0;
         wb_data  <= '0;
         wb_vd    <= '0;
         wb_exc   <= 1'b0;
         wb_src   <= '0;
         for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= '0;
      end else begin
         wb_valid <= w_gnt_any;
         if (w_gnt_any) begin
            wb_index <= req_index[int'(w_gnt_idx)*IW +: IW];
            wb_data  <= req_data[int'(w_gnt_idx)*32 +: 32];
            wb_vd    <= req_vd[int'(w_gnt_idx)*5 +: 5];
            wb_exc   <= req_exc[w_gnt_idx];
            wb_src   <= w_gnt_idx;
            if (w_gnt_idx == SW'(NUM_REQ - 1)) r_rr_ptr <= '0;
            else r_rr_ptr <= w_gnt_idx + 1'b1;
         end
         if (flush) r_rr_ptr <= '0;
         r_urgent <= w_urg_nxt;
         for (int i = 0; i < NUM_REQ; i++) r_wait[i] <= w_wait_nxt[i];
      end
   end

endmodule

// File: tb/tb_cb_wb_arbiter.sv
// tb_cb_wb_arbiter: directed scenarios plus randomized traffic against a queue-free model.
// Two instances share inputs: dut_a uses AGE_LIMIT=8, dut_b uses AGE_LIMIT=2.
module tb_cb_wb_arbiter;

   localparam int NR = 4;
   localparam int IW = 4;

   logic          CLK;
   logic          nRST;
   logic [3:0]    req_valid;
   logic [15:0]   req_index;
   logic [127:0]  req_data;
   logic [19:0]   req_vd;
   logic [3:0]    req_exc;
   logic          flush;

   logic [3:0]  ready_a, ready_b, urg_a, urg_b;
   logic        wb_valid_a, wb_valid_b, wb_exc_a, wb_exc_b;
   logic [3:0]  wb_index_a, wb_index_b;
   logic [31:0] wb_data_a, wb_data_b;
   logic [4:0]  wb_vd_a, wb_vd_b;
   logic [1:0]  wb_src_a, wb_src_b;
   logic [44:0] wb_a, wb_b;

   assign wb_a = {wb_valid_a, wb_index_a, wb_data_a, wb_vd_a, wb_exc_a, wb_src_a};
   assign wb_b = {wb_valid_b, wb_index_b, wb_data_b, wb_vd_b, wb_exc_b, wb_src_b};

   cb_wb_arbiter #(.NUM_REQ(4), .NUM_ENTRY(16), .AGE_LIMIT(8)) dut_a (
      .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_index(req_index),
      .req_data(req_data), .req_vd(req_vd), .req_exc(req_exc),
      .req_ready(ready_a), .flush(flush), .wb_valid(wb_valid_a),
      .wb_index(wb_index_a), .wb_data(wb_data_a), .wb_vd(wb_vd_a),
      .wb_exc(wb_exc_a), .wb_src(wb_src_a), .age_urgent(urg_a)
   );

   cb_wb_arbiter #(.NUM_REQ(4), .NUM_ENTRY(16), .AGE_LIMIT(2)) dut_b (
      .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_index(req_index),
      .req_data(req_data), .req_vd(req_vd), .req_exc(req_exc),
      .req_ready(ready_b), .flush(flush), .wb_valid(wb_valid_b),
      .wb_index(wb_index_b), .wb_data(wb_data_b), .wb_vd(wb_vd_b),
      .wb_exc(wb_exc_b), .wb_src(wb_src_b), .age_urgent(urg_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: m=0 mirrors dut_a, m=1 mirrors dut_b.
   int          al [2] = '{8, 2};
   int          wcnt [2][NR];
   int          rr [2];
   logic        ev [2];
   logic [3:0]  eidx [2];
   logic [31:0] edata [2];
   logic [4:0]  evd [2];
   logic        eexc [2];
   logic [1:0]  esrc [2];

   function automatic int m_grant(input int m);
      int j;
      if (!nRST || flush) return -1;
      for (int i = 0; i < NR; i++)
         if (req_valid[i] && wcnt[m][i] == al[m]) return i;
      for (int k = 0; k < NR; k++) begin
         j = (rr[m] + k) % NR;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   function automatic logic [3:0] m_ready(input int m);
      logic [3:0] r;
      int g;
      r = '0;
      g = m_grant(m);
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   function automatic logic [44:0] m_wb(input int m);
      return {ev[m], eidx[m], edata[m], evd[m], eexc[m], esrc[m]};
   endfunction

   function automatic logic [3:0] m_urg(input int m);
      logic [3:0] u;
      for (int i = 0; i < NR; i++) u[i] = (wcnt[m][i] == al[m]);
      return u;
   endfunction

   // Called between negedge and posedge, while inputs are stable.
   task automatic m_tick(input int m);
      int g;
      g = m_grant(m);
      if (!nRST) begin
         ev[m] = 0; eidx[m] = 0; edata[m] = 0; evd[m] = 0;
         eexc[m] = 0; esrc[m] = 0; rr[m] = 0;
         for (int i = 0; i < NR; i++) wcnt[m][i] = 0;
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (!flush && req_valid[i] && i != g)
               wcnt[m][i] = (wcnt[m][i] + 1 > al[m]) ? al[m] : wcnt[m][i] + 1;
            else
               wcnt[m][i] = 0;
         end
         ev[m] = (g >= 0);
         if (g >= 0) begin
            eidx[m]  = req_index[g*IW +: IW];
            edata[m] = req_data[g*32 +: 32];
            evd[m]   = req_vd[g*5 +: 5];
            eexc[m]  = req_exc[g];
            esrc[m]  = 2'(g);
            rr[m]    = (g + 1) % NR;
         end
         if (flush) rr[m] = 0;
      end
   endtask

   task automatic set_req(input int i, input logic [3:0] idx,
                          input logic [31:0] d, input logic [4:0] vd,
                          input logic e);
      req_index[i*IW +: IW] = idx;
      req_data[i*32 +: 32]  = d;
      req_vd[i*5 +: 5]      = vd;
      req_exc[i]            = e;
   endtask

   task automatic reset_cycle();
      nRST = 1'b0;
      @(negedge CLK);
      m_tick(0); m_tick(1);
      @(posedge CLK); #1;
      nRST = 1'b1;
   endtask

   task automatic test_reset();
      nRST = 1'b0; flush = 1'b0; req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) set_req(i, 4'(i + 1), 32'h1111_0000 + i, 5'(i), 1'b1);
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         n_chk++;
         if ({ready_a, ready_b} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b expected 0000/0000", ready_a, ready_b);
         end
         m_tick(0); m_tick(1);
         @(posedge CLK); #1;
         n_chk++;
         if ({wb_a, urg_a} !== 49'd0 || {wb_b, urg_b} !== 49'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h expected 0", {wb_a, urg_a}, {wb_b, urg_b});
         end
      end
      nRST = 1'b1; req_valid = 4'b0000;
   endtask

   task automatic test_single();
      set_req(2, 4'd5, 32'hDEAD_BEEF, 5'd9, 1'b0);
      req_valid = 4'b0100;
      @(negedge CLK);
      n_chk++;
      if (ready_a !== 4'b0100 || ready_b !== 4'b0100) begin
         n_fail++;
         $display("FAIL single_ready: got %b/%b expected 0100", ready_a, ready_b);
      end
      m_tick(0); m_tick(1);
      @(posedge CLK); #1;
      n_chk++;
      if (wb_valid_a !== 1'b1 || wb_index_a !== 4'd5 ||
          wb_data_a !== 32'hDEAD_BEEF || wb_vd_a !== 5'd9 || wb_src_a !== 2'd2) begin
         n_fail++;
         $display("FAIL single_wb: got v=%b i=%0d d=%h vd=%0d s=%0d expected v=1 i=5 d=deadbeef vd=9 s=2",
                  wb_valid_a, wb_index_a, wb_data_a, wb_vd_a, wb_src_a);
      end
      // Pointer now sits at 3, so requester 3 beats 0 and 1.
      set_req(3, 4'd11, 32'h3333_3333, 5'd3, 1'b1);
      set_req(0, 4'd1, 32'h0000_0001, 5'd1, 1'b0);
      set_req(1, 4'd2, 32'h0000_0002, 5'd2, 1'b0);
      req_valid = 4'b1011;
      @(negedge CLK);
      n_chk++;
      if (ready_a !== 4'b1000) begin
         n_fail++;
         $display("FAIL single_rrptr: got %b expected 1000", ready_a);
      end
      m_tick(0); m_tick(1);
      @(posedge CLK); #1;
      n_chk++;
      if (wb_a !== m_wb(0) || wb_b !== m_wb(1) || wb_src_a !== 2'd3 || wb_exc_a !== 1'b1) begin
         n_fail++;
         $display("FAIL single_wb2: got %h/%h expected %h/%h", wb_a, wb_b, m_wb(0), m_wb(1));
      end
      req_valid = 4'b0000;
      @(negedge CLK);
      m_tick(0); m_tick(1);
      @(posedge CLK); #1;
      n_chk++;
      if (wb_valid_a !== 1'b0 || wb_data_a !== 32'h3333_3333 || wb_a !== m_wb(0)) begin
         n_fail++;
         $display("FAIL idle_hold: got %h expected %h", wb_a, m_wb(0));
      end
   endtask

   task automatic test_round_robin();
      reset_cycle();
      for (int i = 0; i < NR; i++) set_req(i, 4'(8 + i), 32'hC0DE_0000 + i, 5'(16 + i), 1'b0);
      req_valid = 4'b1111;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         n_chk++;
         if (ready_a !== 4'(1 << (c % NR)) || ready_b !== m_ready(1)) begin
            n_fail++;
            $display("FAIL rr_grant c%0d: got %b/%b expected %b/%b",
                     c, ready_a, ready_b, 4'(1 << (c % NR)), m_ready(1));
         end
         m_tick(0); m_tick(1);
         @(posedge CLK); #1;
         n_chk++;
         if (wb_valid_a !== 1'b1 || wb_src_a !== 2'(c % NR) ||
             wb_data_a !== 32'hC0DE_0000 + 32'(c % NR) || wb_b !== m_wb(1)) begin
            n_fail++;
            $display("FAIL rr_wb c%0d: got v=%b s=%0d d=%h expected v=1 s=%0d",
                     c, wb_valid_a, wb_src_a, wb_data_a, c % NR);
         end
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_aging();
      logic [3:0] seq [3];
      seq[0] = 4'b1001; seq[1] = 4'b1010; seq[2] = 4'b1100;
      reset_cycle();
      for (int i = 0; i < NR; i++) set_req(i, 4'(i), 32'hA6E0_0000 + i, 5'(i), 1'b0);
      for (int c = 0; c < 3; c++) begin
         req_valid = seq[c];
         @(negedge CLK);
         if (c == 2) begin
            n_chk++;
            if (ready_b !== 4'b1000 || ready_a !== 4'b0100) begin
               n_fail++;
               $display("FAIL aging_grant: got b=%b a=%b expected b=1000 a=0100", ready_b, ready_a);
            end
         end else begin
            n_chk++;
            if (ready_a !== m_ready(0) || ready_b !== m_ready(1)) begin
               n_fail++;
               $display("FAIL aging_pre c%0d: got %b/%b expected %b/%b",
                        c, ready_a, ready_b, m_ready(0), m_ready(1));
            end
         end
         m_tick(0); m_tick(1);
         @(posedge CLK); #1;
         if (c == 1) begin
            n_chk++;
            if (urg_b[3] !== 1'b1 || urg_a[3] !== 1'b0) begin
               n_fail++;
               $display("FAIL aging_urgent: got b=%b a=%b expected b[3]=1 a[3]=0", urg_b, urg_a);
            end
         end
      end
      n_chk++;
      if (wb_src_b !== 2'd3 || wb_src_a !== 2'd2) begin
         n_fail++;
         $display("FAIL aging_src: got b=%0d a=%0d expected b=3 a=2", wb_src_b, wb_src_a);
      end
   endtask

   task automatic test_flush();
      req_valid = 4'b1111;
      for (int c = 0; c < 2; c++) begin
         @(negedge CLK);
         m_tick(0); m_tick(1);
         @(posedge CLK); #1;
      end
      flush = 1'b1;
      @(negedge CLK);
      n_chk++;
      if (ready_a !== 4'b0000 || ready_b !== 4'b0000) begin
         n_fail++;
         $display("FAIL flush_ready: got %b/%b expected 0000", ready_a, ready_b);
      end
      m_tick(0); m_tick(1);
      @(posedge CLK); #1;
      n_chk++;
      if (wb_valid_a !== 1'b0 || wb_valid_b !== 1'b0 || urg_a !== 4'b0 || urg_b !== 4'b0 ||
          wb_a !== m_wb(0) || wb_b !== m_wb(1)) begin
         n_fail++;
         $display("FAIL flush_state: got %h u=%b / %h u=%b expected %h / %h",
                  wb_a, urg_a, wb_b, urg_b, m_wb(0), m_wb(1));
      end
      flush = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (ready_a !== 4'b0001 || ready_b !== 4'b0001) begin
         n_fail++;
         $display("FAIL flush_rrptr: got %b/%b expected 0001", ready_a, ready_b);
      end
      m_tick(0); m_tick(1);
      @(posedge CLK); #1;
      req_valid = 4'b0000;
   endtask

   task automatic test_mid_reset();
      set_req(1, 4'd7, 32'h1234_5678, 5'd17, 1'b1);
      req_valid = 4'b0010;
      @(negedge CLK);
      n_chk++;
      if (ready_a !== 4'b0010 || ready_b !== 4'b0010) begin
         n_fail++;
         $display("FAIL midrst_grant: got %b/%b expected 0010", ready_a, ready_b);
      end
      m_tick(0); m_tick(1);
      @(posedge CLK); #1;
      nRST = 1'b0;
      @(negedge CLK);
      n_chk++;
      if (ready_a !== 4'b0000 || ready_b !== 4'b0000) begin
         n_fail++;
         $display("FAIL midrst_ready: got %b/%b expected 0000", ready_a, ready_b);
      end
      m_tick(0); m_tick(1);
      @(posedge CLK); #1;
      n_chk++;
      if ({wb_a, urg_a} !== 49'd0 || {wb_b, urg_b} !== 49'd0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got %h/%h expected 0", {wb_a, urg_a}, {wb_b, urg_b});
      end
      nRST = 1'b1;
      set_req(3, 4'd12, 32'hFEED_F00D, 5'd31, 1'b0);
      req_valid = 4'b1000;
      @(negedge CLK);
      n_chk++;
      if (ready_a !== 4'b1000 || ready_b !== 4'b1000) begin
         n_fail++;
         $display("FAIL midrst_after: got %b/%b expected 1000", ready_a, ready_b);
      end
      m_tick(0); m_tick(1);
      @(posedge CLK); #1;
      n_chk++;
      if (wb_valid_a !== 1'b1 || wb_src_a !== 2'd3 || wb_data_a !== 32'hFEED_F00D ||
          wb_b !== m_wb(1)) begin
         n_fail++;
         $display("FAIL midrst_wb: got v=%b s=%0d d=%h expected v=1 s=3 d=feedf00d",
                  wb_valid_a, wb_src_a, wb_data_a);
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_random();
      int ga;
      for (int c = 0; c < 600; c++) begin
         @(negedge CLK);
         ga = m_grant(0);
         n_chk++;
         if (ready_a !== m_ready(0) || ready_b !== m_ready(1)) begin
            n_fail++;
            $display("FAIL rand_ready c%0d: got %b/%b expected %b/%b",
                     c, ready_a, ready_b, m_ready(0), m_ready(1));
         end
         m_tick(0); m_tick(1);
         @(posedge CLK); #1;
         n_chk++;
         if (wb_a !== m_wb(0) || wb_b !== m_wb(1)) begin
            n_fail++;
            $display("FAIL rand_wb c%0d: got %h/%h expected %h/%h",
                     c, wb_a, wb_b, m_wb(0), m_wb(1));
         end
         n_chk++;
         if (urg_a !== m_urg(0) || urg_b !== m_urg(1)) begin
            n_fail++;
            $display("FAIL rand_urgent c%0d: got %b/%b expected %b/%b",
                     c, urg_a, urg_b, m_urg(0), m_urg(1));
         end
         for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && ga == i) begin
               if ($urandom_range(1, 0) == 1)
                  set_req(i, 4'($urandom), $urandom, 5'($urandom), 1'($urandom));
               else
                  req_valid[i] = 1'b0;
            end else if (req_valid[i]) begin
               if ($urandom_range(15, 0) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(2, 0) == 0) begin
               req_valid[i] = 1'b1;
               set_req(i, 4'($urandom), $urandom, 5'($urandom), 1'($urandom));
            end
         end
         flush = ($urandom_range(19, 0) == 0);
         nRST  = ($urandom_range(49, 0) != 0);
      end
      flush = 1'b0;
      nRST  = 1'b1;
   endtask

   initial begin
      nRST = 1'b0; flush = 1'b0; req_valid = '0;
      req_index = '0; req_data = '0; req_vd = '0; req_exc = '0;
      for (int m = 0; m < 2; m++) begin
         rr[m] = 0; ev[m] = 0; eidx[m] = 0; edata[m] = 0;
         evd[m] = 0; eexc[m] = 0; esrc[m] = 0;
         for (int i = 0; i < NR; i++) wcnt[m][i] = 0;
      end
      #1;
      test_reset();
      test_single();
      test_round_robin();
      test_aging();
      test_flush();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
